lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter RD_LANE_REVERSE, default 1; when 1, load data byte lane i arrives on mem_rdata[31-8i:24-8i], otherwise on mem_rdata[8i+7:8i].
REQ-002 SHALL have ports, clock and reset first: clk in 1 clock, all state on rising edge; reset in 1 asynchronous active-high reset.
REQ-003 SHALL have ports: req_valid in 1 core request; req_ready out 1 request accepted when high; req_we in 1 store=1, load=0; req_funct3 in 3 RV32I width/sign code; req_addr in 32 byte address; req_wdata in 32 store data, LSB-aligned.
REQ-004 SHALL have ports: resp_valid out 1 result/ack valid; resp_ready in 1 core takes response; resp_rdata out 32 extended load data; resp_misaligned out 1 alignment or funct3 fault.
REQ-005 SHALL have ports: mem_read out 1; mem_write out 1; mem_byte_enable out 4 (bit i = wdata[8i+7:8i]); mem_addr out 32; mem_wdata out 32 lane-aligned; mem_rdata in 32 combinational read data.

Function
REQ-006 SHALL implement FSM IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-007 SHALL capture we/funct3/addr/wdata when req_valid&&req_ready at a rising edge; the next state SHALL be ACCESS, or RESP if faulted.
REQ-008 SHALL fault on: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 of 011/110/111; store funct3 >010.
REQ-009 SHALL, in ACCESS only, drive mem_addr=captured addr, mem_read=!we, mem_write=we, for exactly one cycle; both SHALL be 0 in all other states.
REQ-010 SHALL drive store byte enables as SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111, and replicate the data: SB {4{b}}, SH {2{h}}, SW word.
REQ-011 SHALL drive mem_byte_enable=0000 on loads and outside ACCESS.
REQ-012 SHALL sample mem_rdata at the edge ending ACCESS, select the byte or half by addr[1:0] after lane mapping, and extend it: LB/LH sign, LBU/LHU zero, LW none.
REQ-013 SHALL hold resp_valid=1 in RESP until resp_ready; RESP->IDLE on resp_valid&&resp_ready.
REQ-014 SHALL set resp_rdata=0 for stores and faults, and resp_misaligned=1 only for faults.
REQ-015 SHALL give this latency: resp_valid first high 2 cycles after acceptance, or 1 cycle on a fault; throughput is 1 request per 3 cycles minimum.
REQ-016 SHALL hold resp_rdata and resp_misaligned stable while resp_valid=1 and resp_ready=0.
REQ-017 SHALL ignore req_valid outside IDLE, with no queuing.

Reset
REQ-018 SHALL on reset go immediately (asynchronously) to IDLE, with req_ready=1 and all other outputs and captured registers 0.
REQ-019 SHALL, when reset is asserted during ACCESS, drop mem_write/mem_read without waiting for a clock; the in-flight request is discarded.

Structure
REQ-020 SHALL put the state encodings and funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010) in shared package lsu_pkg.
REQ-021 SHALL place store alignment, byte-enable generation and load extraction/extension in one combinational sub-module lsu_align; lsu_ctrl holds the FSM and registers.

Verification
REQ-022 SB: addr 0x80000001, wdata 0x000000AB -> in ACCESS mem_write=1, byte_enable=0010, mem_wdata=0xABABABAB, mem_addr=0x80000001; resp_valid 2 cycles after acceptance with rdata=0.
REQ-023 LH/LHU: RD_LANE_REVERSE=0, addr 0x80000002, mem_rdata 0x80011234 -> LH resp_rdata=0xFFFF8001, LHU 0x00008001.
REQ-024 LW: RD_LANE_REVERSE=1, addr 0x80000000, mem_rdata 0x11223344 -> resp_rdata=0x44332211.
REQ-025 Faults: LW at 0x80000006, and load funct3=011 -> mem_read/mem_write never asserted, resp_misaligned=1, resp_valid 1 cycle after acceptance.
REQ-026 Backpressure and reset: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0; assert reset mid-ACCESS of an SW -> mem_write=0 in the same cycle, req_ready=1, no response.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I width codes
// and the request fault check used at acceptance.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Misaligned halves/words and unsupported width codes both fault.
    function automatic logic lsu_fault(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic f;
        f = 1'b1;
        if (we) begin
            case (funct3)
                F3_SB:   f = 1'b0;
                F3_SH:   f = addr_lo[0];
                F3_SW:   f = (addr_lo != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: f = 1'b0;
                F3_LH, F3_LHU: f = addr_lo[0];
                F3_LW:         f = (addr_lo != 2'b00);
                default:       f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: store lane replication and byte enables,
// load lane mapping, byte/half selection and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit RD_LANE_REVERSE = 1'b1
) (
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] word;
    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        byte_enable = '0;
        wdata_lane  = '0;
        case (funct3)
            F3_SB: begin
                byte_enable = 4'b0001 << addr_lo;
                wdata_lane  = {4{wdata[7:0]}};
            end
            F3_SH: begin
                byte_enable = 4'b0011 << addr_lo;
                wdata_lane  = {2{wdata[15:0]}};
            end
            F3_SW: begin
                byte_enable = 4'b1111;
                wdata_lane  = wdata;
            end
            default: begin
                byte_enable = '0;
                wdata_lane  = '0;
            end
        endcase
    end

    // Reversed lanes put byte 0 on the top bits of the bus.
    always_comb begin
        if (RD_LANE_REVERSE)
            word = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
        else
            word = rdata;
        shifted  = word >> {addr_lo, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {24'h000000, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {16'h0000, sel_half};
            F3_LW:   load_data = word;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, performs a
// single-cycle memory access and holds the response until the core takes it.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit RD_LANE_REVERSE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        in_access;

    lsu_align #(
        .RD_LANE_REVERSE(RD_LANE_REVERSE)
    ) u_align (
        .funct3      (cap_funct3),
        .addr_lo     (cap_addr[1:0]),
        .wdata       (cap_wdata),
        .rdata       (mem_rdata),
        .byte_enable (al_be),
        .wdata_lane  (al_wdata),
        .load_data   (al_load)
    );

    // Bus address/data are gated by the registered state so reset clears them at once.
    assign in_access       = (state == ST_ACCESS);
    assign req_ready       = (state == ST_IDLE);
    assign mem_addr        = in_access ? cap_addr : '0;
    assign mem_byte_enable = (in_access && cap_we) ? al_be : '0;
    assign mem_wdata       = (in_access && cap_we) ? al_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            cap_we          <= 1'b0;
            cap_funct3      <= '0;
            cap_addr        <= '0;
            cap_wdata       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        if (lsu_fault(req_we, req_funct3, req_addr[1:0])) begin
                            state           <= ST_RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_misaligned <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_read  <= ~req_we;
                            mem_write <= req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_read        <= 1'b0;
                    mem_write       <= 1'b0;
                    state           <= ST_RESP;
                    resp_valid      <= 1'b1;
                    resp_misaligned <= 1'b0;
                    resp_rdata      <= cap_we ? '0 : al_load;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl, with both read-lane orderings side by side.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [31:0] mem_rdata;

    logic        req_ready   [2];
    logic        resp_valid  [2];
    logic [31:0] resp_rdata  [2];
    logic        resp_mis    [2];
    logic        mem_read    [2];
    logic        mem_write   [2];
    logic [3:0]  mem_be      [2];
    logic [31:0] mem_addr    [2];
    logic [31:0] mem_wdata   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.RD_LANE_REVERSE(1'b0)) u_dut_fwd (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[0]), .resp_misaligned(resp_mis[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .mem_byte_enable(mem_be[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.RD_LANE_REVERSE(1'b1)) u_dut_rev (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata[1]), .resp_misaligned(resp_mis[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .mem_byte_enable(mem_be[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          rev;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rev, logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic fault,
                                logic [3:0] be, logic [31:0] mwdata, logic [31:0] exp_rdata);
        vec_t v;
        v.rev = rev; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.fault = fault; v.be = be; v.mwdata = mwdata;
        v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    initial begin
        vec_t v;
        int r;
        logic [31:0] held;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req_ready%0d", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("rst_resp_valid%0d", d), 32'(resp_valid[d]), 32'd0);
            chk($sformatf("rst_mem_rw%0d", d), 32'({mem_read[d], mem_write[d]}), 32'd0);
            chk($sformatf("rst_mem_addr%0d", d), mem_addr[d], 32'd0);
            chk($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        //            rev we f3      addr          wdata         rdata         flt be      mwdata        rdata_exp
        vecs.push_back(mk(0, 1, 3'b000, 32'h80000001, 32'h000000AB, 32'h0,        0, 4'b0010, 32'hABABABAB, 32'h0));
        vecs.push_back(mk(0, 0, 3'b001, 32'h80000002, 32'h0,        32'h80011234, 0, 4'b0000, 32'h0,        32'hFFFF8001));
        vecs.push_back(mk(0, 0, 3'b101, 32'h80000002, 32'h0,        32'h80011234, 0, 4'b0000, 32'h0,        32'h00008001));
        vecs.push_back(mk(1, 0, 3'b010, 32'h80000000, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h44332211));
        vecs.push_back(mk(0, 0, 3'b010, 32'h80000006, 32'h0,        32'h11223344, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 3'b011, 32'h80000000, 32'h0,        32'h11223344, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h80000002, 32'h1234BEEF, 32'h0,        0, 4'b1100, 32'hBEEFBEEF, 32'h0));
        vecs.push_back(mk(0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 0, 3'b000, 32'h80000003, 32'h0,        32'h80011234, 0, 4'b0000, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk(1, 0, 3'b100, 32'h80000001, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h00000022));
        vecs.push_back(mk(1, 0, 3'b000, 32'h80000002, 32'h0,        32'h11228344, 0, 4'b0000, 32'h0,        32'hFFFFFF83));
        vecs.push_back(mk(1, 0, 3'b001, 32'h80000002, 32'h0,        32'h11228344, 0, 4'b0000, 32'h0,        32'h00004483));
        vecs.push_back(mk(0, 1, 3'b001, 32'h80000001, 32'h0000BEEF, 32'h0,        1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 3'b011, 32'h80000000, 32'h0000BEEF, 32'h0,        1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 3'b001, 32'h80000001, 32'h0,        32'h80011234, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h80000003, 32'h1234567F, 32'h0,        0, 4'b1000, 32'h7F7F7F7F, 32'h0));
        vecs.push_back(mk(0, 0, 3'b010, 32'h80000000, 32'h0,        32'h11223344, 0, 4'b0000, 32'h0,        32'h11223344));

        foreach (vecs[i]) begin
            v = vecs[i];
            r = v.rev;
            mem_rdata = v.rdata;
            drive_req(v.we, v.f3, v.addr, v.wdata);
            chk($sformatf("v%0d_req_ready_busy", i), 32'(req_ready[r]), 32'd0);
            if (!v.fault) begin
                chk($sformatf("v%0d_acc_resp_valid", i), 32'(resp_valid[r]), 32'd0);
                chk($sformatf("v%0d_mem_read", i), 32'(mem_read[r]), 32'(!v.we));
                chk($sformatf("v%0d_mem_write", i), 32'(mem_write[r]), 32'(v.we));
                chk($sformatf("v%0d_mem_addr", i), mem_addr[r], v.addr);
                chk($sformatf("v%0d_byte_en", i), 32'(mem_be[r]), 32'(v.be));
                if (v.we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata[r], v.mwdata);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_rw_after", i), 32'({mem_read[r], mem_write[r]}), 32'd0);
            end else begin
                chk($sformatf("v%0d_fault_rw", i), 32'({mem_read[r], mem_write[r]}), 32'd0);
            end
            chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid[r]), 32'd1);
            chk($sformatf("v%0d_resp_rdata", i), resp_rdata[r], v.exp_rdata);
            chk($sformatf("v%0d_resp_mis", i), 32'(resp_mis[r]), 32'(v.fault));
            @(negedge clk);
            resp_ready = 1'b1;
            @(posedge clk);
            #1;
            resp_ready = 1'b0;
            chk($sformatf("v%0d_resp_done", i), 32'(resp_valid[r]), 32'd0);
            chk($sformatf("v%0d_req_ready_back", i), 32'(req_ready[r]), 32'd1);
        end

        // Backpressure: response held for 5 cycles while new requests and bus data change.
        mem_rdata = 32'h80011234;
        drive_req(1'b0, 3'b001, 32'h80000002, 32'h0);
        @(posedge clk);
        #1;
        held = resp_rdata[0];
        chk("bp_first_rdata", held, 32'hFFFF8001);
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h80000010;
            mem_rdata = 32'h0000_0000 + 32'(c);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_resp_valid", c), 32'(resp_valid[0]), 32'd1);
            chk($sformatf("bp%0d_resp_rdata", c), resp_rdata[0], 32'hFFFF8001);
            chk($sformatf("bp%0d_resp_mis", c), 32'(resp_mis[0]), 32'd0);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready[0]), 32'd0);
            chk($sformatf("bp%0d_no_access", c), 32'({mem_read[0], mem_write[0]}), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("bp_release_valid", 32'(resp_valid[0]), 32'd0);
        chk("bp_release_ready", 32'(req_ready[0]), 32'd1);

        // Reset in the middle of a store access: bus strobes drop before any clock edge.
        drive_req(1'b1, 3'b010, 32'h80000008, 32'hCAFEF00D);
        chk("rst_acc_write_before", 32'(mem_write[0]), 32'd1);
        chk("rst_acc_be_before", 32'(mem_be[0]), 32'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_acc_write", 32'(mem_write[0]), 32'd0);
        chk("rst_acc_be", 32'(mem_be[0]), 32'd0);
        chk("rst_acc_addr", mem_addr[0], 32'd0);
        chk("rst_acc_req_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_acc_resp_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_post%0d_no_resp", c), 32'(resp_valid[0]), 32'd0);
            chk($sformatf("rst_post%0d_idle", c), 32'(req_ready[0]), 32'd1);
        end
        resp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
